// File: rtl/detector_datapath_pkg.sv
// Shared sizing and start pattern for the serial detector datapath.
package detector_datapath_pkg;

  localparam int unsigned PAT_W = 4;
  localparam logic [PAT_W-1:0] PATTERN = 4'b1101;
  localparam int unsigned PAY_W = 8;
  localparam int unsigned CNT_W = $clog2(PAY_W);
  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam int unsigned DCNT_W = PAY_W;

endpackage

// File: rtl/detector_datapath_if.sv
// Strobe/status bundle between the post-controller (master) and the datapath (slave).
interface detector_datapath_if;
  import detector_datapath_pkg::*;

  logic              sin;
  logic              set_8;
  logic              en_detector;
  logic              en_counter;
  logic              load_downcounter;
  logic              en_downcounter;
  logic              w_detector;
  logic              co_counter;
  logic              co_downcounter;
  logic [PAY_W-1:0]  payload;
  logic [DCNT_W-1:0] dcount;

  modport master (
    output sin, set_8, en_detector, en_counter, load_downcounter, en_downcounter,
    input  w_detector, co_counter, co_downcounter, payload, dcount
  );

  modport slave (
    input  sin, set_8, en_detector, en_counter, load_downcounter, en_downcounter,
    output w_detector, co_counter, co_downcounter, payload, dcount
  );

endinterface

// File: rtl/detector_datapath_down_counter_sat.sv
// Loadable down-counter that stops at zero instead of wrapping; clr beats load beats en.
module detector_datapath_down_counter_sat #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o,
  output logic             zero_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = d_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o    = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/detector_datapath.sv
// Start-pattern detector, 8-bit serial payload capture and saturating down-counter.
module detector_datapath
  import detector_datapath_pkg::*;
(
  input logic                clk,
  input logic                rst,
  detector_datapath_if.slave bus
);

  logic [PAT_W-1:0]  window_d, window_q;
  logic [FILL_W-1:0] fill_d, fill_q;
  logic              w_det_d, w_det_q;
  logic              running_d, running_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              co_cnt_d, co_cnt_q;
  logic [PAY_W-1:0]  payload_d, payload_q;
  logic              loaded_d, loaded_q;
  logic              dc_load, dc_en, dc_zero;
  logic [DCNT_W-1:0] dc_q;

  always_comb begin
    window_d  = window_q;
    fill_d    = fill_q;
    w_det_d   = w_det_q;
    running_d = running_q;
    cnt_d     = cnt_q;
    co_cnt_d  = co_cnt_q;
    payload_d = payload_q;
    loaded_d  = loaded_q;
    if (bus.set_8) begin
      window_d  = '0;
      fill_d    = '0;
      w_det_d   = 1'b0;
      running_d = 1'b0;
      cnt_d     = '0;
      co_cnt_d  = 1'b0;
      payload_d = '0;
      loaded_d  = 1'b0;
    end else if (bus.load_downcounter) begin
      loaded_d = 1'b1;
      co_cnt_d = 1'b0;
    end else if (bus.en_counter) begin
      // Arming edge samples nothing; the first payload bit lands on the next edge.
      running_d = 1'b1;
      cnt_d     = '0;
      co_cnt_d  = 1'b0;
      w_det_d   = 1'b0;
    end else begin
      if (bus.en_detector) begin
        window_d = {window_q[PAT_W-2:0], bus.sin};
        if (fill_q != FILL_W'(PAT_W)) fill_d = fill_q + FILL_W'(1);
        if ((window_d == PATTERN) && (fill_d == FILL_W'(PAT_W))) w_det_d = 1'b1;
      end
      if (running_q) begin
        payload_d = {payload_q[PAY_W-2:0], bus.sin};
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(PAY_W - 1)) begin
          running_d = 1'b0;
          co_cnt_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_q  <= '0;
      fill_q    <= '0;
      w_det_q   <= 1'b0;
      running_q <= 1'b0;
      cnt_q     <= '0;
      co_cnt_q  <= 1'b0;
      payload_q <= '0;
      loaded_q  <= 1'b0;
    end else begin
      window_q  <= window_d;
      fill_q    <= fill_d;
      w_det_q   <= w_det_d;
      running_q <= running_d;
      cnt_q     <= cnt_d;
      co_cnt_q  <= co_cnt_d;
      payload_q <= payload_d;
      loaded_q  <= loaded_d;
    end
  end

  // Decrement yields to any higher-priority strobe on the same edge.
  assign dc_load = bus.load_downcounter & ~bus.set_8;
  assign dc_en   = bus.en_downcounter & ~bus.set_8 & ~bus.load_downcounter & ~bus.en_counter;

  detector_datapath_down_counter_sat #(
    .Width (DCNT_W)
  ) u_down_counter (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (bus.set_8),
    .load_i (dc_load),
    .en_i   (dc_en),
    .d_i    (payload_q),
    .q_o    (dc_q),
    .zero_o (dc_zero)
  );

  assign bus.w_detector     = w_det_q;
  assign bus.co_counter     = co_cnt_q;
  assign bus.co_downcounter = loaded_q & dc_zero;
  assign bus.payload        = payload_q;
  assign bus.dcount         = dc_q;

endmodule

// File: tb/tb_detector_datapath.sv
// Directed and randomized checks of detector_datapath against a bit-history reference model.
module tb_detector_datapath;
  import detector_datapath_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  detector_datapath_if bus ();

  detector_datapath dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: recent detector bits, payload as an integer, bits captured so far.
  bit m_hist[$];
  bit m_wdet, m_run, m_cocnt, m_loaded;
  int m_got, m_payload, m_dcount;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_hist.delete();
    m_wdet = 0; m_run = 0; m_cocnt = 0; m_loaded = 0;
    m_got = 0; m_payload = 0; m_dcount = 0;
  endfunction

  function automatic int hist_value();
    int v = 0;
    foreach (m_hist[i]) v = (v << 1) | int'(m_hist[i]);
    return v;
  endfunction

  function automatic void model_edge();
    if (bus.set_8) begin
      model_clear();
    end else if (bus.load_downcounter) begin
      m_dcount = m_payload; m_loaded = 1; m_cocnt = 0;
    end else if (bus.en_counter) begin
      m_run = 1; m_got = 0; m_cocnt = 0; m_wdet = 0;
    end else begin
      if (bus.en_detector) begin
        m_hist.push_back(bus.sin);
        if (m_hist.size() > PAT_W) void'(m_hist.pop_front());
        if (m_hist.size() == PAT_W && hist_value() == int'(PATTERN)) m_wdet = 1;
      end
      if (bus.en_downcounter && m_dcount > 0) m_dcount--;
      if (m_run) begin
        m_payload = ((m_payload << 1) | int'(bus.sin)) % (1 << PAY_W);
        m_got++;
        if (m_got == PAY_W) begin m_run = 0; m_cocnt = 1; end
      end
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".w_detector"}, 32'(bus.w_detector), 32'(m_wdet));
    chk({tag, ".co_counter"}, 32'(bus.co_counter), 32'(m_cocnt));
    chk({tag, ".co_down"}, 32'(bus.co_downcounter), 32'(m_loaded && m_dcount == 0));
    chk({tag, ".payload"}, 32'(bus.payload), 32'(m_payload));
    chk({tag, ".dcount"}, 32'(bus.dcount), 32'(m_dcount));
  endtask

  task automatic drive(input bit s, input bit st, input bit ed, input bit ec, input bit ld,
                       input bit dn);
    bus.sin = s; bus.set_8 = st; bus.en_detector = ed;
    bus.en_counter = ec; bus.load_downcounter = ld; bus.en_downcounter = dn;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic capture(input logic [7:0] v);
    drive(0, 0, 0, 1, 0, 0); step("arm");
    for (int i = PAY_W - 1; i >= 0; i--) begin
      drive(v[i], 0, 0, 0, 0, 0); step("cap");
    end
  endtask

  initial begin
    logic [7:0] bits;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_all("reset");

    // Plain match, then overlapped match.
    drive(0, 1, 0, 0, 0, 0); step("set8");
    bits = 8'b0000_1101;
    for (int i = 3; i >= 0; i--) begin drive(bits[i], 0, 1, 0, 0, 0); step("det"); end
    chk("wdet_1101", 32'(bus.w_detector), 32'd1);
    drive(0, 1, 0, 0, 0, 0); step("set8");
    bits = 8'b0001_1101;
    for (int i = 4; i >= 0; i--) begin
      drive(bits[i], 0, 1, 0, 0, 0); step("ovl");
      if (i == 1) chk("wdet_ovl_4th", 32'(bus.w_detector), 32'd0);
    end
    chk("wdet_ovl_5th", 32'(bus.w_detector), 32'd1);

    // Capture A6; w_detector drops on the arming edge, co_counter after exactly 8 more.
    drive(0, 0, 0, 1, 0, 0); step("arm");
    chk("wdet_clr_arm", 32'(bus.w_detector), 32'd0);
    bits = 8'hA6;
    for (int i = 7; i >= 0; i--) begin
      drive(bits[i], 0, 0, 0, 0, 0); step("capA6");
      chk("co_cnt_timing", 32'(bus.co_counter), (i == 0) ? 32'd1 : 32'd0);
    end
    chk("payload_A6", 32'(bus.payload), 32'hA6);

    // Short sequence never fills the window.
    drive(0, 1, 0, 0, 0, 0); step("set8");
    bits = 8'b0000_0101;
    for (int i = 2; i >= 0; i--) begin drive(bits[i], 0, 1, 0, 0, 0); step("short"); end
    chk("wdet_short", 32'(bus.w_detector), 32'd0);

    // Countdown from 3 with load and enable on the same edge, then saturation.
    capture(8'h03);
    drive(0, 0, 0, 0, 1, 1); step("load3");
    chk("dcount_load3", 32'(bus.dcount), 32'd3);
    chk("co_cnt_clr_load", 32'(bus.co_counter), 32'd0);
    for (int k = 2; k >= 0; k--) begin
      drive(0, 0, 0, 0, 0, 1); step("dec");
      chk("dcount_dec", 32'(bus.dcount), 32'(k));
    end
    chk("co_down_at0", 32'(bus.co_downcounter), 32'd1);
    drive(0, 0, 0, 0, 0, 1); step("sat");
    chk("dcount_sat", 32'(bus.dcount), 32'd0);

    // Zero payload flags immediately after load.
    drive(0, 1, 0, 0, 0, 0); step("set8");
    chk("co_down_set8", 32'(bus.co_downcounter), 32'd0);
    capture(8'h00);
    drive(0, 0, 0, 0, 1, 0); step("load0");
    chk("co_down_load0", 32'(bus.co_downcounter), 32'd1);

    // set_8 mid-countdown.
    capture(8'h05);
    drive(0, 0, 0, 0, 1, 0); step("load5");
    chk("dcount_load5", 32'(bus.dcount), 32'd5);
    drive(0, 1, 0, 0, 0, 0); step("set8mid");
    chk("dcount_set8mid", 32'(bus.dcount), 32'd0);
    chk("co_down_set8mid", 32'(bus.co_downcounter), 32'd0);

    // Random strobes, including simultaneous ones resolved by priority.
    for (int c = 0; c < 3000; c++) begin
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 2),
            ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 4),
            ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 40));
      step("rand");
      if (c == 1500) begin
        // Asynchronous reset lands between edges and must act at once.
        #2 rst = 1'b1;
        #1;
        model_clear();
        check_all("rst_mid");
        @(posedge clk);
        #1 rst = 1'b0;
        check_all("rst_rel");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
